// File: rtl/hdmi_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_timing_gen
// Purpose  : 1080p60 raster timing (hs/vs/de) with an 8-bar colour test pattern.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_timing_gen #(
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic [7:0] rgb_r,
    output logic [7:0] rgb_g,
    output logic [7:0] rgb_b
);

    localparam int         BAR_W       = H_ACTIVE / 8;
    localparam logic [11:0] c_h_last   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] c_v_last   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] c_h_active = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
    localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [23:0] rgb_q, rgb_d;
    logic [2:0]  w_bar;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == c_h_last) begin
            h_cnt_d = 12'd0;
            v_cnt_d = (v_cnt_q == c_v_last) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    // Compare chain: the last threshold passed selects the bar, clamping at 7.
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt_q >= 12'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
    end

    always_comb begin
        de_d = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active);
        hs_d = ((h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end)) ? HS_POL : ~HS_POL;
        vs_d = ((v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end)) ? VS_POL : ~VS_POL;
        // Bar order white..black is a binary count on inverted (G,R,B) bits.
        rgb_d = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
        if (!de_d) begin
            rgb_d = 24'h000000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= 24'h000000;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hs    = hs_q;
    assign vs    = vs_q;
    assign de    = de_q;
    assign rgb_r = rgb_q[23:16];
    assign rgb_g = rgb_q[15:8];
    assign rgb_b = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_timing_gen
// Purpose  : Directed self-checking bench: full-size line timing plus a
//            vertically shrunk instance for frame-level behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs, vs, de;
    logic [7:0] rgb_r, rgb_g, rgb_b;
    logic       s_hs, s_vs, s_de;
    logic [7:0] s_r, s_g, s_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hdmi_timing_gen dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .de(de),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
    );

    // Small frame: 4 active lines, vsync on lines 5..6, total 8 lines.
    hdmi_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk(clk), .rst(rst), .hs(s_hs), .vs(s_vs), .de(s_de),
        .rgb_r(s_r), .rgb_g(s_g), .rgb_b(s_b)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic        ln_de  [0:2200];
    logic        ln_hs  [0:2200];
    logic [23:0] ln_rgb [0:2200];
    logic [26:0] f1     [0:17599];
    bit          line_has_de [0:7];

    int pix_idx [13] = '{0, 239, 240, 479, 480, 720, 960, 1200, 1440, 1680, 1919, 1920, 2199};
    logic [23:0] pix_exp [13] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h00FFFF,
                                  24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000,
                                  24'h000000, 24'h000000, 24'h000000};

    initial begin
        logic [26:0] o_s;
        logic        prev_vs;
        int f1_de, f1_vs, vs_rise, vs_misalign, blank_bad, f2_diff, full_vs;
        int de_cnt, de_first_low, hs_cnt, hs_first, de_lines;

        f1_de = 0; f1_vs = 0; vs_rise = -1; vs_misalign = 0; blank_bad = 0;
        f2_diff = 0; full_vs = 0; prev_vs = 1'b0;
        for (int l = 0; l < 8; l++) line_has_de[l] = 1'b0;

        // Reset held for 10 cycles
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("reset_out", {5'd0, hs, vs, de, rgb_r, rgb_g, rgb_b}, 32'd0);
        end
        chk("reset_small", {5'd0, s_hs, s_vs, s_de, s_r, s_g, s_b}, 32'd0);
        rst = 1'b0;

        // Two small frames; the full-size instance covers lines 0..15 meanwhile
        for (int i = 0; i < 35200; i++) begin
            tick();
            if (i <= 2200) begin
                ln_de[i]  = de;
                ln_hs[i]  = hs;
                ln_rgb[i] = {rgb_r, rgb_g, rgb_b};
            end
            if (vs) full_vs++;
            o_s = {s_hs, s_vs, s_de, s_r, s_g, s_b};
            if (s_vs != prev_vs && (i % 2200) != 0) vs_misalign++;
            if (i < 17600) begin
                f1[i] = o_s;
                if (s_de) f1_de++;
                if (s_vs) f1_vs++;
                if (s_vs && !prev_vs && vs_rise < 0) vs_rise = i;
                if (s_de) line_has_de[i / 2200] = 1'b1;
                if ((i / 2200) == 7 && (s_de || {s_r, s_g, s_b} != 24'd0)) blank_bad++;
            end else if (o_s !== f1[i - 17600]) begin
                f2_diff++;
            end
            prev_vs = s_vs;
        end

        chk("first_pixel_de", {31'd0, ln_de[0]}, 32'd1);
        for (int k = 0; k < 13; k++)
            chk($sformatf("rgb_px%0d", pix_idx[k]), {8'd0, ln_rgb[pix_idx[k]]}, {8'd0, pix_exp[k]});

        de_cnt = 0; de_first_low = -1; hs_cnt = 0; hs_first = -1;
        for (int p = 0; p < 2200; p++) begin
            if (ln_de[p]) de_cnt++;
            else if (de_first_low < 0) de_first_low = p;
            if (ln_hs[p]) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = p;
            end
        end
        chk("de_count_line", de_cnt, 1920);
        chk("de_first_low", de_first_low, 1920);
        chk("hs_rise_px", hs_first, 2008);
        chk("hs_width", hs_cnt, 44);
        chk("line1_start", {7'd0, ln_de[2200], ln_rgb[2200]}, {7'd0, 1'b1, 24'hFFFFFF});
        chk("full_vs_idle", full_vs, 0);

        de_lines = 0;
        for (int l = 0; l < 8; l++) if (line_has_de[l]) de_lines++;
        chk("frame_de_lines", de_lines, 4);
        chk("frame_de_cycles", f1_de, 7680);
        chk("vs_rise_cycle", vs_rise, 11000);
        chk("vs_high_cycles", f1_vs, 4400);
        chk("vs_line_aligned", vs_misalign, 0);
        chk("vblank_line_dark", blank_bad, 0);
        chk("frame2_equal", f2_diff, 0);

        // Mid-line reset on line 16, pixel 1000 of the full-size instance
        repeat (1000) tick();
        chk("pre_reset_de", {31'd0, de}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midline_reset", {5'd0, hs, vs, de, rgb_r, rgb_g, rgb_b}, 32'd0);
        chk("midline_reset_s", {5'd0, s_hs, s_vs, s_de, s_r, s_g, s_b}, 32'd0);
        rst = 1'b0;
        tick();
        chk("restart_px0", {5'd0, hs, vs, de, rgb_r, rgb_g, rgb_b}, {5'd0, 3'b001, 24'hFFFFFF});
        repeat (240) tick();
        chk("restart_px240", {8'd0, rgb_r, rgb_g, rgb_b}, 32'h00FFFF00);
        repeat (1767) tick();
        chk("restart_px2007_hs", {31'd0, hs}, 32'd0);
        tick();
        chk("restart_px2008_hs", {31'd0, hs}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
